miner_ctrl: RTL
===============

MINER_CTRL -- requirements
Module: miner_ctrl

Interface
REQ-001 SHALL have parameter MSG_SIZE, default 32, nonce/message width in bits.
REQ-002 SHALL have parameter HASH_W, default 256, digest and target width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles to wait for core done per hash.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a sweep.
REQ-007 SHALL have port abort, input, 1, cancel sweep in progress.
REQ-008 SHALL have port nonce_start, input, MSG_SIZE, first nonce, sampled on accepted start.
REQ-009 SHALL have port nonce_end, input, MSG_SIZE, last nonce, sampled on accepted start.
REQ-010 SHALL have port target, input, HASH_W, success threshold, sampled on accepted start.
REQ-011 SHALL have port core_message, output, MSG_SIZE, message driven to the hash core.
REQ-012 SHALL have port core_rst, output, 1, active-high reset pulse to the hash core.
REQ-013 SHALL have port core_enable, output, 1, enable to the hash core.
REQ-014 SHALL have port core_done, input, 1, hash core completion level.
REQ-015 SHALL have port core_hashed, input, HASH_W, hash core digest, valid on core_done rise.
REQ-016 SHALL have ports busy, found, exhausted, error, output, 1 each, status flags.
REQ-017 SHALL have ports nonce_found (MSG_SIZE), hash_found (HASH_W), hash_count (32), output, results.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, HASH, CHECK, FOUND, EXHAUSTED, ERROR.
REQ-019 SHALL accept start only in IDLE, FOUND, EXHAUSTED, ERROR; ignore it elsewhere.
REQ-020 On accepted start: latch inputs, nonce := nonce_start, clear found/exhausted/error, hash_count := 0, go LOAD.
REQ-021 LOAD (1 cycle): core_message := nonce, core_rst = 1, core_enable = 0; go HASH.
REQ-022 HASH: core_enable = 1, core_rst = 0, core_message held; wait-counter increments each cycle.
REQ-023 SHALL detect core_done rising edge via a registered copy; a level held high from a prior hash does not count.
REQ-024 On core_done rise in HASH: capture core_hashed, hash_count += 1 (saturating), core_enable = 0, go CHECK.
REQ-025 CHECK (1 cycle): if captured hash < target (unsigned, HASH_W bits, strict) -> FOUND, nonce_found/hash_found loaded.
REQ-026 CHECK, not found, nonce == nonce_end -> EXHAUSTED; else nonce := nonce + 1 mod 2^MSG_SIZE, go LOAD.
REQ-027 Sweep SHALL wrap: nonce_end < nonce_start covers nonce_start..max, 0..nonce_end; start == end hashes exactly one nonce.
REQ-028 If wait-counter reaches TIMEOUT in HASH without done rise -> ERROR, error = 1, core_enable = 0.
REQ-029 abort in LOAD/HASH/CHECK SHALL go IDLE next cycle, core_enable = 0, results unchanged; abort elsewhere ignored; abort wins over simultaneous done.
REQ-030 busy = 1 exactly in LOAD, HASH, CHECK; found/exhausted/error held until next accepted start.

Reset
REQ-031 On rst low: state IDLE, all outputs 0 (core_rst 0, core_enable 0, busy/found/exhausted/error 0, results 0), counters 0, edge register 0.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no result reported.

Structure
REQ-033 Shared package miner_pkg SHALL hold the state enum type and default widths/TIMEOUT constants.
REQ-034 SHALL instantiate no hash core; sweeper and comparator inline, optional sub-module hash_lt (unsigned HASH_W compare).

Verification
REQ-035 Bench SHALL drive a real sha_256 core (MSG_SIZE 32); start=end=0x61626364 ("abcd"), target=0x88d4266f...3f031589+1 -> found, nonce_found=0x61626364, hash_found=88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589, hash_count=1.
REQ-036 Same nonce, target = that exact digest -> exhausted=1, found=0, hash_count=1.
REQ-037 target=0, start=5, end=7 -> exhausted, hash_count=3, core_message sequence 5,6,7.
REQ-038 target=0, start=0xFFFFFFFE, end=0x00000001 -> messages FFFFFFFE, FFFFFFFF, 0, 1; hash_count=4.
REQ-039 core_done tied low, TIMEOUT=64 -> error=1 exactly 64 cycles after HASH entry, busy=0.
REQ-040 abort asserted mid-HASH, and rst pulsed low mid-HASH -> IDLE next cycle / immediately, core_enable=0, found=0.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: shared types and default sizing for the nonce-sweep controller.
//   state_e       - controller FSM states
//   *_DEF         - default MSG_SIZE / HASH_W / TIMEOUT values
//   sat_inc32()   - saturating increment for the 32-bit hash counter
package miner_pkg;

    localparam int MSG_SIZE_DEF = 32;
    localparam int HASH_W_DEF   = 256;
    localparam int TIMEOUT_DEF  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HASH,
        ST_CHECK,
        ST_FOUND,
        ST_EXHAUSTED,
        ST_ERROR
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/miner_ctrl_hash_lt.sv
// hash_lt: unsigned strict less-than over a W-bit digest.
//   a_i, b_i - operands
//   lt_o     - 1 when a_i < b_i
module hash_lt #(
    parameter int W = 256
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o
);

    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/miner_ctrl.sv
// miner_ctrl: sweeps a nonce range through an external hash core and stops on
// the first digest strictly below the target.
//   clk, rst                  - clock, async active-low reset
//   start, abort              - begin a sweep / cancel a running sweep
//   nonce_start/end, target   - sweep range and threshold, latched on start
//   core_message/rst/enable   - drive to the hash core
//   core_done, core_hashed    - completion level and digest from the core
//   busy/found/exhausted/error- status flags (sticky until next start)
//   nonce_found, hash_found,
//   hash_count                - results of the last sweep
module miner_ctrl
    import miner_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int HASH_W   = HASH_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [MSG_SIZE-1:0] nonce_start,
    input  logic [MSG_SIZE-1:0] nonce_end,
    input  logic [HASH_W-1:0]   target,
    output logic [MSG_SIZE-1:0] core_message,
    output logic                core_rst,
    output logic                core_enable,
    input  logic                core_done,
    input  logic [HASH_W-1:0]   core_hashed,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                error,
    output logic [MSG_SIZE-1:0] nonce_found,
    output logic [HASH_W-1:0]   hash_found,
    output logic [31:0]         hash_count
);

    localparam int            TW        = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    state_e              state_q;
    logic [MSG_SIZE-1:0] nonce_q, end_q, msg_q, nfound_q;
    logic [HASH_W-1:0]   target_q, hash_q, hfound_q;
    logic [TW-1:0]       wait_q;
    logic [31:0]         count_q;
    logic                done_q;
    logic                core_rst_q, core_en_q;
    logic                busy_q, found_q, exh_q, err_q;

    logic                done_rise_d;
    logic                below_d;
    logic [MSG_SIZE-1:0] nonce_nxt_d;

    // Only a fresh 0->1 transition counts; a level left high by the previous
    // hash is ignored because done_q is still high alongside it.
    assign done_rise_d = core_done & ~done_q;
    assign nonce_nxt_d = nonce_q + MSG_SIZE'(1);

    hash_lt #(.W(HASH_W)) u_lt (
        .a_i  (hash_q),
        .b_i  (target_q),
        .lt_o (below_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            nonce_q    <= '0;
            end_q      <= '0;
            msg_q      <= '0;
            nfound_q   <= '0;
            target_q   <= '0;
            hash_q     <= '0;
            hfound_q   <= '0;
            wait_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b0;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            found_q    <= 1'b0;
            exh_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= core_done;
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                    if (start) begin
                        nonce_q    <= nonce_start;
                        end_q      <= nonce_end;
                        target_q   <= target;
                        msg_q      <= nonce_start;
                        count_q    <= '0;
                        found_q    <= 1'b0;
                        exh_q      <= 1'b0;
                        err_q      <= 1'b0;
                        core_rst_q <= 1'b1;
                        core_en_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_rst_q <= 1'b0;
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        core_en_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= ST_HASH;
                    end
                end
                ST_HASH: begin
                    // abort takes priority over a done rise in the same cycle
                    if (abort) begin
                        core_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (done_rise_d) begin
                        hash_q    <= core_hashed;
                        count_q   <= sat_inc32(count_q);
                        core_en_q <= 1'b0;
                        state_q   <= ST_CHECK;
                    end else if (wait_q == WAIT_LAST) begin
                        // TIMEOUT-th HASH cycle without a rise
                        core_en_q <= 1'b0;
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_ERROR;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (below_d) begin
                        found_q  <= 1'b1;
                        nfound_q <= nonce_q;
                        hfound_q <= hash_q;
                        busy_q   <= 1'b0;
                        state_q  <= ST_FOUND;
                    end else if (nonce_q == end_q) begin
                        exh_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_EXHAUSTED;
                    end else begin
                        // modular increment gives the wrap-around sweep
                        nonce_q    <= nonce_nxt_d;
                        msg_q      <= nonce_nxt_d;
                        core_rst_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                default: begin
                    core_rst_q <= 1'b0;
                    core_en_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_message = msg_q;
    assign core_rst     = core_rst_q;
    assign core_enable  = core_en_q;
    assign busy         = busy_q;
    assign found        = found_q;
    assign exhausted    = exh_q;
    assign error        = err_q;
    assign nonce_found  = nfound_q;
    assign hash_found   = hfound_q;
    assign hash_count   = count_q;

endmodule
